button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder_pkg.sv | 29 ++
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_event_timer.sv | 29 ++
 rtl/button_event_decoder.sv | 148 ++++++++++++++
 tb/tb_button_event_decoder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder: FSM state encoding,
// event indices used by the menu FSM, and a small sizing helper.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    localparam int unsigned EV_SHORT  = 0;
    localparam int unsigned EV_DOUBLE = 1;
    localparam int unsigned EV_LONG   = 2;
    localparam int unsigned EV_REPEAT = 3;
    localparam int unsigned EV_COUNT  = 4;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button decoder bundle: debounced level and enable in, event pulses
// and status levels out. master = consumer side, slave = decoder.
interface button_event_decoder_if;
    logic btn_level;
    logic enable;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_pulse;
    logic held;
    logic busy;

    modport master (
        output btn_level, enable,
        input  short_press, double_press, long_press,
        input  repeat_pulse, held, busy
    );

    modport slave (
        input  btn_level, enable,
        output short_press, double_press, long_press,
        output repeat_pulse, held, busy
    );
endinterface

// File: rtl/button_event_timer.sv
// Loadable up-counter with a terminal-compare flag.
// Ports: clk, rst (async high), load_i/load_val_i, inc_i, term_i, hit_o.
module button_event_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into short/double/long events plus
// auto-repeat ticks. Ports: clk, reset (async high), bus (slave).
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_TIME   = 2000,
    parameter int unsigned DOUBLE_GAP  = 300,
    parameter int unsigned REPEAT_TIME = 200
) (
    input  logic clk,
    input  logic reset,
    button_event_decoder_if.slave bus
);

    localparam int unsigned W =
        $clog2(max3(LONG_TIME, DOUBLE_GAP, REPEAT_TIME) + 1);

    localparam logic [W-1:0] T_LONG = W'(LONG_TIME - 1);
    localparam logic [W-1:0] T_GAP  = W'(DOUBLE_GAP - 1);
    localparam logic [W-1:0] T_REP  = W'(REPEAT_TIME - 1);
    localparam logic [W-1:0] ONE    = W'(1);

    state_e state_q, state_d;
    logic [EV_COUNT-1:0] ev_q, ev_d;
    logic held_q, busy_q;

    logic         load;
    logic [W-1:0] load_val;
    logic         inc;
    logic [W-1:0] term;
    logic         hit;

    button_event_timer #(.W(W)) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .inc_i      (inc),
        .term_i     (term),
        .hit_o      (hit)
    );

    // Terminal count depends on which phase the counter is timing.
    always_comb begin
        term = T_LONG;
        case (state_q)
            ST_WAIT2: term = T_GAP;
            ST_LONG:  term = T_REP;
            default:  term = T_LONG;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ev_d     = '0;
        load     = 1'b0;
        load_val = '0;
        inc      = 1'b0;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            load    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.btn_level) begin
                        state_d  = ST_PRESS1;
                        load     = 1'b1;
                        load_val = ONE;
                    end
                end
                ST_PRESS1: begin
                    if (!bus.btn_level) begin
                        state_d  = ST_WAIT2;
                        load     = 1'b1;
                        load_val = ONE;
                    end else if (hit) begin
                        state_d        = ST_LONG;
                        load           = 1'b1;
                        ev_d[EV_LONG]  = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_WAIT2: begin
                    // A new press wins over the gap timeout.
                    if (bus.btn_level) begin
                        state_d = ST_PRESS2;
                        load    = 1'b1;
                    end else if (hit) begin
                        state_d        = ST_IDLE;
                        load           = 1'b1;
                        ev_d[EV_SHORT] = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_PRESS2: begin
                    // No timeout here; the counter simply holds.
                    if (!bus.btn_level) begin
                        state_d         = ST_IDLE;
                        load            = 1'b1;
                        ev_d[EV_DOUBLE] = 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!bus.btn_level) begin
                        state_d = ST_IDLE;
                        load    = 1'b1;
                    end else if (hit) begin
                        load            = 1'b1;
                        ev_d[EV_REPEAT] = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    load    = 1'b1;
                end
            endcase
        end
    end

    // Status levels are registered from the next state so they track
    // the registered state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ev_q    <= '0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
            held_q  <= (state_d == ST_LONG);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.short_press  = ev_q[EV_SHORT];
    assign bus.double_press = ev_q[EV_DOUBLE];
    assign bus.long_press   = ev_q[EV_LONG];
    assign bus.repeat_pulse = ev_q[EV_REPEAT];
    assign bus.held         = held_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_TIME=20,
// DOUBLE_GAP=8, REPEAT_TIME=5. Output vector: short,double,long,rep,held,busy.
module tb_button_event_decoder;

    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] B  = 6'b000001;
    localparam logic [5:0] SH = 6'b100000;
    localparam logic [5:0] DB = 6'b010000;
    localparam logic [5:0] LG = 6'b001011;
    localparam logic [5:0] H  = 6'b000011;
    localparam logic [5:0] RP = 6'b000111;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    button_event_decoder_if bus ();

    button_event_decoder #(
        .LONG_TIME   (20),
        .DOUBLE_GAP  (8),
        .REPEAT_TIME (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {bus.short_press, bus.double_press, bus.long_press,
                bus.repeat_pulse, bus.held, bus.busy};
    endfunction

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] o;
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, exp);
        end
    endtask

    task automatic step(input logic b, input logic [5:0] exp,
                        input string tag);
        @(negedge clk);
        bus.btn_level = b;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    // n samples of level b; the last one expects 'last', others 'mid'.
    task automatic run(input logic b, input int n, input logic [5:0] mid,
                       input logic [5:0] last, input string tag);
        for (int i = 1; i <= n; i++)
            step(b, (i == n) ? last : mid, tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_level = 1'b0;
        bus.enable = 1'b1;
        #12;
        chk("reset_state", Z);
        @(negedge clk);
        reset = 1'b0;

        // Short press
        run(1, 5, B, B, "s1_hi");
        run(0, 8, B, SH, "s1_lo");
        run(0, 3, Z, Z, "s1_idle");

        // Double press
        run(1, 5, B, B, "s2_hi1");
        run(0, 3, B, B, "s2_gap");
        run(1, 4, B, B, "s2_hi2");
        step(0, DB, "s2_double");
        run(0, 9, Z, Z, "s2_quiet");

        // Long press with repeats
        run(1, 19, B, B, "s3_pre");
        step(1, LG, "s3_long");
        for (int k = 21; k <= 32; k++)
            step(1, (k == 25 || k == 30) ? RP : H, "s3_held");
        step(0, Z, "s3_release");
        run(0, 3, Z, Z, "s3_quiet");

        // LONG_TIME boundary: 19 highs stays short
        run(1, 19, B, B, "s4a_hi");
        run(0, 8, B, SH, "s4a_lo");
        run(0, 2, Z, Z, "s4a_quiet");

        // LONG_TIME boundary: 20 highs is long
        run(1, 19, B, B, "s4b_hi");
        step(1, LG, "s4b_long");
        step(0, Z, "s4b_release");
        run(0, 2, Z, Z, "s4b_quiet");

        // DOUBLE_GAP boundary: 7 lows still pairs
        run(1, 5, B, B, "s5a_hi1");
        run(0, 7, B, B, "s5a_gap");
        step(1, B, "s5a_press2");
        step(0, DB, "s5a_double");
        run(0, 9, Z, Z, "s5a_quiet");

        // DOUBLE_GAP boundary: 8 lows reports short, then fresh press
        run(1, 5, B, B, "s5b_hi1");
        run(0, 8, B, SH, "s5b_gap");
        step(1, B, "s5b_fresh");
        run(0, 8, B, SH, "s5b_short2");
        run(0, 2, Z, Z, "s5b_quiet");

        // Async reset mid-LONG
        run(1, 19, B, B, "s6a_pre");
        step(1, LG, "s6a_long");
        run(1, 2, H, H, "s6a_held");
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("s6a_async", Z);
        @(posedge clk);
        #1;
        chk("s6a_inreset", Z);
        @(negedge clk);
        bus.btn_level = 1'b0;
        reset = 1'b0;
        run(0, 10, Z, Z, "s6a_after");

        // enable drop at sample 15 of a press
        run(1, 14, B, B, "s6b_pre");
        bus.enable = 1'b0;
        step(1, Z, "s6b_disable");
        run(1, 10, Z, Z, "s6b_off");
        bus.enable = 1'b1;
        run(1, 3, B, B, "s6b_newpress");
        run(0, 8, B, SH, "s6b_short");
        run(0, 2, Z, Z, "s6b_quiet");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
